// File: rtl/fft_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_stream_ctrl_if
//   Bundles every handshake and data signal of fft_stream_ctrl so the
//   controller and its surroundings connect through a single port.
//
//   Signals
//     s_valid/s_ready/s_data     upstream beat stream into the controller
//     m_valid/m_ready/m_data     downstream beat stream out of the controller
//     m_last                     final beat of each output frame
//     core_next/core_x           frame-start pulse and input beats to the core
//     core_next_out/core_y       frame-announce pulse and output beats of the core
//     inflight                   frames issued to the core and not yet fully read
//     err                        sticky protocol error
//
//   Modports
//     master : the controller view (drives s_ready, m_*, core_next, core_x,
//              inflight, err)
//     slave  : the surroundings view (upstream source, downstream sink, core)
// -----------------------------------------------------------------------------
interface fft_stream_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 16
);

  logic                      s_valid;
  logic                      s_ready;
  logic [LANES*DATA_W-1:0]   s_data;

  logic                      m_valid;
  logic                      m_ready;
  logic [LANES*DATA_W-1:0]   m_data;
  logic                      m_last;

  logic                      core_next;
  logic [LANES*DATA_W-1:0]   core_x;
  logic                      core_next_out;
  logic [LANES*DATA_W-1:0]   core_y;

  logic [4:0]                inflight;
  logic                      err;

  modport master (
    input  s_valid, s_data, m_ready, core_next_out, core_y,
    output s_ready, m_valid, m_data, m_last, core_next, core_x, inflight, err
  );

  modport slave (
    output s_valid, s_data, m_ready, core_next_out, core_y,
    input  s_ready, m_valid, m_data, m_last, core_next, core_x, inflight, err
  );

endinterface

// File: rtl/fft_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stream_ctrl
//   Streaming wrapper around a frame-based FFT core.  Input beats are
//   collected into a one-frame buffer, then replayed to the core on
//   consecutive cycles after a one-cycle core_next pulse.  The core's output
//   frames are captured into a FIFO sized for MAX_INFLIGHT frames and
//   streamed downstream with an m_last marker on each frame's final beat.
//   The number of frames issued to the core but not yet fully read
//   downstream is bounded by MAX_INFLIGHT, which guarantees the output FIFO
//   never has to drop a captured beat.
//
//   Parameters
//     DATA_W        width of one real word
//     LANES         words per beat
//     FRAME_BEATS   beats per FFT frame (1..64)
//     MAX_INFLIGHT  frames the output FIFO can hold (1..16)
//
//   Ports
//     i_clk         clock, rising edge
//     i_rst_n       asynchronous active-low reset
//     bus           fft_stream_ctrl_if.master (streams, core link, status)
//     o_frames_in   (optional) count of core_next pulses, wraps at 2^32
//     o_frames_out  (optional) count of m_last handshakes, wraps at 2^32
//
//   Build option
//     FFT_STREAM_CTRL_STATS_EN  when defined, adds o_frames_in/o_frames_out
//                               and their counters; otherwise they are absent.
// -----------------------------------------------------------------------------
module fft_stream_ctrl #(
  parameter int DATA_W       = 32,
  parameter int LANES        = 16,
  parameter int FRAME_BEATS  = 1,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fft_stream_ctrl_if.master  bus
`ifdef FFT_STREAM_CTRL_STATS_EN
  ,
  output logic [31:0]        o_frames_in,
  output logic [31:0]        o_frames_out
`endif
);

  localparam int BEAT_W = LANES * DATA_W;
  localparam int BW     = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int DEPTH  = MAX_INFLIGHT * FRAME_BEATS;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [4:0]    MAX_FR    = 5'(MAX_INFLIGHT);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_FEED  = 2'd2;

  // Input side
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_s_ready;
  logic [BW-1:0]     r_in_wr;
  logic [BW-1:0]     r_in_rd;
  logic [BEAT_W-1:0] r_in_buf [FRAME_BEATS];
  logic              w_s_fire;
  logic              w_issue;

  // Frame accounting
  logic [4:0]        r_inflight;
  logic [4:0]        r_pending;
  logic              r_err;

  // Capture side
  logic              r_cap_active;
  logic [BW-1:0]     r_cap_cnt;
  logic              w_cap_start;
  logic              w_cap_err;

  // Output FIFO
  logic [BEAT_W-1:0] r_fifo [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_out_beat;
  logic              w_full;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic              w_m_valid;
  logic              w_m_last;
  logic              w_frame_done;

  // ---------------------------------------------------------------------------
  // Stage: input buffer fill and frame issue
  // ---------------------------------------------------------------------------
  // s_ready is a register so it carries no combinational path from m_ready;
  // it simply mirrors "the FSM will be in FILL during the next cycle".
  assign w_s_fire = bus.s_valid & r_s_ready;

  // A frame may only be issued while the output FIFO still has room for a
  // whole frame, i.e. while fewer than MAX_INFLIGHT frames are outstanding.
  assign w_issue  = (r_state == ST_START) && (r_inflight < MAX_FR);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL:  if (w_s_fire && (r_in_wr == LAST_BEAT)) w_state_nxt = ST_START;
      ST_START: if (w_issue)                             w_state_nxt = ST_FEED;
      ST_FEED:  if (r_in_rd == LAST_BEAT)                w_state_nxt = ST_FILL;
      default:                                           w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_FILL;
      r_s_ready <= 1'b0;
      r_in_wr   <= '0;
      r_in_rd   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt == ST_FILL);
      if (w_s_fire) begin
        r_in_wr <= (r_in_wr == LAST_BEAT) ? '0 : r_in_wr + 1'b1;
      end
      // The read index wraps back to 0 on the last FEED cycle, ready for
      // the next frame.
      if (r_state == ST_FEED) begin
        r_in_rd <= (r_in_rd == LAST_BEAT) ? '0 : r_in_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_s_fire) begin
      r_in_buf[r_in_wr] <= bus.s_data;
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.core_next = w_issue;
  assign bus.core_x    = (r_state == ST_FEED) ? r_in_buf[r_in_rd] : '0;

  // ---------------------------------------------------------------------------
  // Stage: frame accounting and core output capture
  // ---------------------------------------------------------------------------
  // r_pending counts frames issued to the core whose output has not started
  // arriving yet.  A core_next_out with nothing pending, or one arriving in
  // the middle of a capture, is a protocol violation and is dropped.
  assign w_cap_err   = bus.core_next_out && (r_cap_active || (r_pending == 5'd0));
  assign w_cap_start = bus.core_next_out && !w_cap_err;

  assign w_frame_done = w_fifo_rd && w_m_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight   <= '0;
      r_pending    <= '0;
      r_err        <= 1'b0;
      r_cap_active <= 1'b0;
      r_cap_cnt    <= '0;
    end else begin
      case ({w_issue, w_frame_done})
        2'b10:   r_inflight <= r_inflight + 5'd1;
        2'b01:   r_inflight <= r_inflight - 5'd1;
        default: r_inflight <= r_inflight;
      endcase

      case ({w_issue, w_cap_start})
        2'b10:   r_pending <= r_pending + 5'd1;
        2'b01:   r_pending <= r_pending - 5'd1;
        default: r_pending <= r_pending;
      endcase

      if (w_cap_err) begin
        r_err <= 1'b1;
      end

      // Capture window: FRAME_BEATS cycles starting the cycle after the pulse.
      if (w_cap_start) begin
        r_cap_active <= 1'b1;
        r_cap_cnt    <= '0;
      end else if (r_cap_active) begin
        if (r_cap_cnt == LAST_BEAT) begin
          r_cap_active <= 1'b0;
          r_cap_cnt    <= '0;
        end else begin
          r_cap_cnt    <= r_cap_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.inflight = r_inflight;
  assign bus.err      = r_err;

  // ---------------------------------------------------------------------------
  // Stage: output FIFO and downstream stream
  // ---------------------------------------------------------------------------
  assign w_full    = (r_count == FULL_CNT);
  assign w_m_valid = (r_count != '0);
  assign w_fifo_rd = w_m_valid && bus.m_ready;
  // A write into a full FIFO is allowed only when a read frees a slot in the
  // same cycle.
  assign w_fifo_wr = r_cap_active && (!w_full || w_fifo_rd);
  assign w_m_last  = w_m_valid && (r_out_beat == LAST_BEAT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_beat <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_fifo_rd) begin
        r_rd_ptr   <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
        r_out_beat <= (r_out_beat == LAST_BEAT) ? '0 : r_out_beat + 1'b1;
      end
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // core_y lands in a register before it can reach m_data.
  always_ff @(posedge i_clk) begin
    if (w_fifo_wr) begin
      r_fifo[r_wr_ptr] <= bus.core_y;
    end
  end

  assign bus.m_valid = w_m_valid;
  assign bus.m_data  = r_fifo[r_rd_ptr];
  assign bus.m_last  = w_m_last;

`ifdef FFT_STREAM_CTRL_STATS_EN
  // ---------------------------------------------------------------------------
  // Stage: frame statistics
  // ---------------------------------------------------------------------------
  logic [31:0] r_frames_in;
  logic [31:0] r_frames_out;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frames_in  <= '0;
      r_frames_out <= '0;
    end else begin
      if (w_issue)      r_frames_in  <= r_frames_in + 32'd1;
      if (w_frame_done) r_frames_out <= r_frames_out + 32'd1;
    end
  end

  assign o_frames_in  = r_frames_in;
  assign o_frames_out = r_frames_out;
`endif

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_stream_ctrl
//   Scoreboard bench for fft_stream_ctrl with FRAME_BEATS=4, MAX_INFLIGHT=2.
//   An echoing core model (fixed latency) sits on the core link.  Accepted
//   input beats are pushed into expectation queues; independent monitors
//   check core_x, the downstream stream and the inflight count.
// -----------------------------------------------------------------------------
module tb_fft_stream_ctrl;

  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int FB  = 4;
  localparam int MI  = 2;
  localparam int BWD = DW * LN;
  localparam int LAT = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_stream_ctrl_if #(.DATA_W(DW), .LANES(LN)) bus ();

`ifdef FFT_STREAM_CTRL_STATS_EN
  logic [31:0] frames_in;
  logic [31:0] frames_out;
`endif

  fft_stream_ctrl #(
    .DATA_W(DW), .LANES(LN), .FRAME_BEATS(FB), .MAX_INFLIGHT(MI)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef FFT_STREAM_CTRL_STATS_EN
    ,
    .o_frames_in  (frames_in),
    .o_frames_out (frames_out)
`endif
  );

  typedef struct {
    logic [BWD-1:0] d;
    logic           l;
  } exp_t;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exp_t           exp_q[$];       // expected downstream beats
  logic [BWD-1:0] core_exp_q[$];  // beats the core must receive, in order
  int             acc_cnt      = 0;
  int             nxt_cnt      = 0;
  int             ref_inflight = 0;
  int             mr_mode      = 0;  // 0: m_ready low, 1: high, 2: random
  bit             inj_req      = 1'b0;

  // core model state
  logic [BWD-1:0] core_beats[$];
  int             core_ready[$];
  int             feed_left = 0;
  int             out_left  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Core model: records each fed frame, echoes it LAT cycles later
  // ---------------------------------------------------------------------------
  initial begin : core_model
    bus.core_next_out = 1'b0;
    bus.core_y        = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.core_next_out = 1'b0;
      bus.core_y        = '0;
      if (rst_n) begin
        if (inj_req) begin
          bus.core_next_out = 1'b1;
          inj_req = 1'b0;
        end else if (out_left > 0) begin
          bus.core_y = core_beats.pop_front();
          out_left--;
        end else if (core_ready.size() > 0 && cyc >= core_ready[0]) begin
          void'(core_ready.pop_front());
          bus.core_next_out = 1'b1;
          out_left = FB;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        core_beats.delete();
        core_ready.delete();
        feed_left = 0;
        out_left  = 0;
      end else begin
        if (feed_left > 0) begin
          if (core_exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL core_x_extra: got 0x%0h, required no beat", bus.core_x);
          end else begin
            chk("core_x", bus.core_x, core_exp_q.pop_front());
          end
          core_beats.push_back(bus.core_x);
          feed_left--;
          if (feed_left == 0) core_ready.push_back(cyc + LAT);
        end else begin
          chk("core_x_idle", bus.core_x, 64'd0);
        end
        if (bus.core_next) begin
          nxt_cnt++;
          chk("core_next_during_feed", 64'(feed_left), 64'd0);
          feed_left = FB;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // m_ready driver
  // ---------------------------------------------------------------------------
  initial begin : mready_drv
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output monitor: downstream scoreboard and inflight reference
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("inflight", 64'(bus.inflight), 64'(ref_inflight));
        if (bus.core_next) ref_inflight++;
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, required no output", bus.m_data);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", bus.m_data, e.d);
            chk("m_last", 64'(bus.m_last), 64'(e.l));
          end
          if (bus.m_last) ref_inflight--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // mode 0: continuous, 1: every other cycle, 2: random
  task automatic drive_beats(input int n, input int mode);
    int got = 0;
    int tmo = 0;
    bit tog = 1'b0;
    while (got < n && tmo < 2000) begin
      @(posedge clk);
      #1;
      tmo++;
      tog = ~tog;
      case (mode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = tog;
        default: bus.s_valid = ($urandom_range(0, 2) != 0);
      endcase
      bus.s_data = {$urandom, $urandom};
      if (bus.s_valid && bus.s_ready) begin
        exp_t e;
        e.d = bus.s_data;
        e.l = ((acc_cnt % FB) == FB - 1);
        exp_q.push_back(e);
        core_exp_q.push_back(bus.s_data);
        acc_cnt++;
        got++;
      end
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    chk("drive_accept", 64'(got), 64'(n));
  endtask

  task automatic wait_drain(input int maxc);
    int c = 0;
    while ((exp_q.size() != 0 || bus.inflight != 5'd0) && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_inflight", 64'(bus.inflight), 64'd0);
  endtask

  task automatic wait_pulses(input int base, input int want, input int maxc);
    int c = 0;
    while ((nxt_cnt - base) < want && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},   64'(bus.s_ready),   64'd0);
    chk({tag, "_m_valid"},   64'(bus.m_valid),   64'd0);
    chk({tag, "_m_last"},    64'(bus.m_last),    64'd0);
    chk({tag, "_core_next"}, 64'(bus.core_next), 64'd0);
    chk({tag, "_core_x"},    bus.core_x,         64'd0);
    chk({tag, "_inflight"},  64'(bus.inflight),  64'd0);
    chk({tag, "_err"},       64'(bus.err),       64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int base;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_ready_pre_edge", 64'(bus.s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("s_ready_first_edge", 64'(bus.s_ready), 64'd1);

    // Single frame, free-flowing output
    mr_mode = 1;
    drive_beats(FB, 0);
    wait_drain(300);

    // Gappy input, random downstream readiness
    mr_mode = 2;
    drive_beats(3 * FB, 1);
    wait_drain(600);

    // Backpressure: only MAX_INFLIGHT frames may be issued
    mr_mode = 0;
    base = nxt_cnt;
    drive_beats(3 * FB, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("held_pulses",    64'(nxt_cnt - base), 64'd2);
    chk("held_inflight",  64'(bus.inflight),   64'd2);
    chk("held_s_ready",   64'(bus.s_ready),    64'd0);
    chk("held_core_next", 64'(bus.core_next),  64'd0);
    chk("held_m_valid",   64'(bus.m_valid),    64'd1);
    mr_mode = 1;
    wait_pulses(base, 3, 300);
    chk("third_pulse", 64'(nxt_cnt - base), 64'd3);
    wait_drain(600);

    // Spurious core_next_out with nothing issued
    repeat (4) @(posedge clk);
    #1;
    chk("err_before_inject", 64'(bus.err), 64'd0);
    inj_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("err_after_inject", 64'(bus.err), 64'd1);
    repeat (FB + 4) @(posedge clk);
    #1;
    chk("inject_m_valid", 64'(bus.m_valid), 64'd0);
    chk("inject_inflight", 64'(bus.inflight), 64'd0);

    // Reset during FEED of the second frame
    mr_mode = 1;
    base = nxt_cnt;
    drive_beats(2 * FB, 0);
    wait_pulses(base, 2, 300);
    chk("second_issue", 64'(nxt_cnt - base), 64'd2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    core_exp_q.delete();
    acc_cnt      = 0;
    ref_inflight = 0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

    // Fresh frame after reset
    drive_beats(FB, 0);
    begin
      int c = 0;
      while (bus.inflight != 5'd1 && c < 100) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    chk("fresh_inflight_one", 64'(bus.inflight), 64'd1);
    wait_drain(300);

    // Four more frames: five frames since reset
    mr_mode = 2;
    drive_beats(4 * FB, 2);
    wait_drain(1500);
`ifdef FFT_STREAM_CTRL_STATS_EN
    chk("frames_in",  64'(frames_in),  64'd5);
    chk("frames_out", 64'(frames_out), 64'd5);
`endif

    // Random traffic
    drive_beats(12 * FB, 2);
    wait_drain(3000);
    mr_mode = 1;
    drive_beats(6 * FB, 0);
    wait_drain(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_stream_ctrl.md
FFT_STREAM_CTRL -- requirements
Module: fft_stream_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of one real word.
REQ-002 Parameter LANES, default 16, words per beat (core X0..X(LANES-1) / Y0..Y(LANES-1)).
REQ-003 Parameter FRAME_BEATS, default 1, beats per FFT frame; legal values 1 to 64.
REQ-004 Parameter MAX_INFLIGHT, default 4, frames the output buffer holds; legal values 1 to 16.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 s_valid / s_ready  in / out  1 / 1  upstream beat handshake.
REQ-008 s_data  in  LANES*DATA_W  input beat; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-009 m_valid / m_ready  out / in  1 / 1  downstream beat handshake.
REQ-010 m_data  out  LANES*DATA_W  output beat, same lane packing.
REQ-011 m_last  out  1  high on the final beat of each frame.
REQ-012 core_next  out  1  one-cycle frame-start pulse to the FFT core.
REQ-013 core_x  out  LANES*DATA_W  beat driven to the core.
REQ-014 core_next_out  in  1  core pulse announcing that an output frame follows.
REQ-015 core_y  in  LANES*DATA_W  beat from the core.
REQ-016 inflight  out  5  frames issued to the core whose output has not yet been fully read.
REQ-017 err  out  1  sticky protocol error.

Function
REQ-018 The input path SHALL use an FSM with states FILL, START and FEED.
REQ-019 FILL: s_ready SHALL be 1; each s_valid&&s_ready beat SHALL be written to an input buffer of FRAME_BEATS entries.
REQ-020 On the FRAME_BEATS-th accepted beat, the FSM SHALL go to START.
REQ-021 START: s_ready SHALL be 0; the FSM SHALL wait until inflight < MAX_INFLIGHT, then assert core_next for exactly one cycle and go to FEED.
REQ-022 FEED: core_x SHALL present buffer entries 0..FRAME_BEATS-1 on consecutive cycles, with entry 0 in the cycle immediately after core_next.
REQ-023 FEED: after the last entry, the FSM SHALL return to FILL.
REQ-024 core_x SHALL be 0 whenever the FSM is not in FEED.
REQ-025 inflight SHALL increment on the core_next pulse and decrement when the downstream handshake completes with m_last=1.
REQ-026 When the increment and decrement events coincide, inflight SHALL be unchanged.
REQ-027 On core_next_out, core_y SHALL be captured on the FRAME_BEATS consecutive cycles starting one cycle later.
REQ-028 Captured beats SHALL be written into an output FIFO of MAX_INFLIGHT*FRAME_BEATS entries; the FIFO SHALL never be written when full.
REQ-029 m_valid SHALL equal FIFO-not-empty; m_data SHALL be the FIFO head, registered (no combinational path from core_y to m_data).
REQ-030 m_last SHALL be derived from a beat counter that wraps at FRAME_BEATS.
REQ-031 A FIFO read and write in the same cycle SHALL both take effect when the FIFO is full or empty.
REQ-032 err SHALL set when core_next_out arrives while a capture is in progress.
REQ-033 err SHALL set when core_next_out arrives while the issued-but-not-captured frame count is 0.
REQ-034 On either error the offending core_next_out SHALL be ignored; err SHALL clear only on reset.
REQ-035 There SHALL be no combinational path from m_ready to s_ready.

Reset
REQ-036 While reset=0, the FSM SHALL be FILL and all counters and FIFO pointers SHALL be 0.
REQ-037 While reset=0, s_ready, m_valid, m_last, core_next, core_x, inflight and err SHALL all be 0.
REQ-038 s_ready SHALL rise on the first clk edge after reset deasserts.
REQ-039 Assertion of reset mid-frame SHALL discard all buffered and in-flight data; no partial frame SHALL appear on m_* after reset.

Configuration
REQ-040 With macro FFT_STREAM_CTRL_STATS_EN defined, the block SHALL add outputs frames_in (32 bits) and frames_out (32 bits).
REQ-041 frames_in SHALL count core_next pulses and frames_out SHALL count m_last handshakes; both SHALL wrap at 2^32 and reset to 0.
REQ-042 With FFT_STREAM_CTRL_STATS_EN undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-043 Defaults; one beat 0x00000001..0x00000010; core model of latency 6 echoes X -> core_next one cycle after the beat, m_data equals the input beat, m_last=1, inflight returns to 0.
REQ-044 FRAME_BEATS=4; s_valid toggled every other cycle -> core_x beats are contiguous after core_next, and the output order matches the input order.
REQ-045 MAX_INFLIGHT=2, m_ready=0 and 3 frames offered -> exactly 2 core_next pulses, FSM held in START, inflight=2; releasing m_ready -> third pulse occurs.
REQ-046 core_next_out injected with no frame issued -> err=1, FIFO unchanged, m_valid stays 0.
REQ-047 reset pulled low during FEED of frame 2 -> all outputs 0 at once; after release, a fresh frame completes normally with inflight=1 then 0.
REQ-048 With FFT_STREAM_CTRL_STATS_EN defined, after 5 frames are fully read -> frames_in=5 and frames_out=5.
